mux16_rr_scheduler: RTL and testbench
=====================================

// Module: mux16_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one 16:1 select datapath between 16 requesters.
//  It arbitrates req[15:0] and drives a one-hot grant plus the matching 4-bit sel,
//  which is wired directly to the 16:1 mux select input.
//  A grant is held until the owner signals done or drops its request.
//  Sits between requester logic and the shared 16:1 mux.
// PARAMETERS
//  MAX_HOLD   8   max GRANT cycles before forced preemption (ARB_TIMEOUT_EN only); legal 2..255
//  PTR_RESET  0   round-robin pointer value after reset (0..15)
// PORTS
//  clk      in   1   rising-edge clock
//  rst_n    in   1   asynchronous active-low reset
//  req      in   16  request vector; bit i = requester i
//  done     in   1   current owner releases grant; ignored while valid=0
//  gnt      out  16  one-hot grant; all-zero when idle
//  sel      out  4   binary index of owner; wired to the 16:1 mux select
//  valid    out  1   1 while gnt is non-zero
//  preempt  out  1   1-cycle pulse on forced release (ARB_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=0, sel=0, valid=0, preempt=0, ptr=PTR_RESET, hold_cnt=0.
//  All outputs are registered. Reset can assert in any state, including mid-grant; all
//    state clears immediately, and the first arbitration after release starts from PTR_RESET.
//  Arbitration search: first set bit of the candidate vector, starting at ptr and
//    scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (wrap mod 16).
//  FSM states are IDLE and GRANT.
//  IDLE:
//    - If |req = 1: at the next edge, gnt = onehot(w), sel = w, valid = 1, go to GRANT.
//      Latency: request sampled at edge N, grant visible after edge N.
//    - If req = 0: stay in IDLE; sel holds its last value, gnt = 0, valid = 0.
//  GRANT, owner o:
//    - Release condition: done=1, or req[o]=0, or forced timeout (see CONFIGURATION).
//    - While no release condition holds: outputs are stable, hold_cnt increments (saturating).
//    - On release, ptr <= (o+1) mod 16 and the same edge re-arbitrates over
//      candidates = req & ~onehot(o), searching from the new ptr.
//    - If any candidate exists, it is granted back-to-back with no idle cycle.
//      Otherwise, go to IDLE with gnt = 0 and valid = 0.
//    - The releasing owner is never re-granted on its own release edge, even if req[o] stays 1.
//  Invariants:
//    - gnt is always one-hot or zero.
//    - When valid = 1, gnt[sel] = 1.
//    - gnt only moves on release edges.
//  Simultaneous events:
//    - done together with req[o] falling is a single release.
//    - New requests arriving on a release edge participate in that edge's arbitration.
//  Fairness: any requester that holds req high is granted within 15 grants.
//  hold_cnt resets to 0 on every new grant.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//    - An 8-bit hold_cnt counts owner cycles in GRANT (first GRANT cycle counts as 0).
//    - When hold_cnt = MAX_HOLD-1 and (req & ~onehot(o)) != 0, the next edge forces a release.
//    - The forced release follows the normal release rules, and preempt=1 for that one cycle.
//    - With no competing request, the owner keeps the grant indefinitely and no preempt occurs.
//  ARB_TIMEOUT_EN undefined: no hold counter is built, preempt is tied to 0, and the
//    grant ends only on done or a request drop.
// TESTING
//  1. Reset, then req=16'h0001 held -> one edge later gnt=16'h0001, sel=0, valid=1;
//     after done pulse -> gnt=0, valid=0.
//  2. req=16'hFFFF held, done pulsed every 2nd cycle
//     -> sel sequence 0,1,2,...,15,0 (wrap), with no idle cycles between grants.
//  3. ptr=14 (after owner 13 released), req=16'h0009
//     -> next owner 0 (wrap), then 3; requester 14 is never granted.
//  4. Owner 5 drops req[5] while req=16'h0120 is pending -> next edge sel=8, gnt=16'h0100.
//  5. Pull rst_n low mid-grant (sel=7) -> gnt/sel/valid clear at once;
//     after release with req=16'h0180 -> sel=7 (search from ptr=0).
//  6. [ARB_TIMEOUT_EN, MAX_HOLD=4] owner 2 never asserts done, req=16'h0014
//     -> after 4 GRANT cycles preempt=1 for one cycle, sel=4;
//     with req=16'h0004 only -> no preemption.

Source files
------------

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler for a shared 16:1 select datapath (16 requesters).
// Optional hold timeout with forced preemption when ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   req      in   16  request vector, bit i = requester i
//   done     in   1   current owner releases the grant (ignored while idle)
//   gnt      out  16  one-hot grant, zero when idle
//   sel      out  4   binary owner index, drives the 16:1 mux select
//   valid    out  1   high while gnt is non-zero
//   preempt  out  1   one-cycle pulse on a forced release (0 without ARB_TIMEOUT_EN)
//
// Parameters:
//   MAX_HOLD   owner cycles before forced release (ARB_TIMEOUT_EN only), 2..255
//   PTR_RESET  round-robin pointer value after reset, 0..15
module mux16_rr_scheduler #(
   parameter int MAX_HOLD  = 8,
   parameter int PTR_RESET = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        done,
   output logic [15:0] gnt,
   output logic [3:0]  sel,
   output logic        valid,
   output logic        preempt
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] gnt_q, gnt_d;
   logic [3:0]  sel_q, sel_d;
   logic        valid_q, valid_d;
   logic        preempt_q, preempt_d;
   logic [3:0]  ptr_q, ptr_d;

   logic [15:0] competitors;
   logic        force_rel;
   logic        release_ev;
   logic [3:0]  next_ptr;

   // First set bit of cand, scanning start, start+1, ... with 4-bit wrap.
   function automatic logic [3:0] rr_pick(input logic [15:0] cand,
                                          input logic [3:0]  start);
      logic [3:0] idx;
      logic       found;
      rr_pick = start;
      found   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         idx = start + 4'(i);
         if (!found && cand[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // The releasing owner is masked so it cannot win its own release edge.
   assign competitors = req & ~gnt_q;
   assign next_ptr    = sel_q + 4'd1;
   assign release_ev  = (state_q == GRANT) &&
                        (done || !req[sel_q] || force_rel);

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   logic [7:0] hold_q, hold_d;
   logic       grant_load;

   // A fresh grant happens from IDLE with any request, or on a release
   // that still has a competitor to hand over to.
   assign grant_load = ((state_q == IDLE) && (|req)) ||
                       (release_ev && (|competitors));

   // Preemption only when someone else is actually waiting.
   assign force_rel = (state_q == GRANT) &&
                      (hold_q == HOLD_LIM) && (|competitors);

   always_comb begin
      hold_d = hold_q;
      if (grant_load)
         hold_d = 8'd0;
      else if ((state_q == GRANT) && (hold_q != 8'hFF))
         hold_d = hold_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hold_q <= 8'd0;
      else
         hold_q <= hold_d;
   end
`else
   assign force_rel = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      valid_d   = valid_q;
      ptr_d     = ptr_q;
      preempt_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               sel_d   = rr_pick(req, ptr_q);
               gnt_d   = 16'd1 << sel_d;
               valid_d = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (release_ev) begin
               ptr_d     = next_ptr;
               preempt_d = force_rel;
               if (|competitors) begin
                  sel_d = rr_pick(competitors, next_ptr);
                  gnt_d = 16'd1 << sel_d;
               end else begin
                  gnt_d   = 16'd0;
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            gnt_d   = 16'd0;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 16'd0;
         sel_q     <= 4'd0;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
         ptr_q     <= 4'(PTR_RESET);
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
         preempt_q <= preempt_d;
         ptr_q     <= ptr_d;
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign valid   = valid_q;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed testbench for mux16_rr_scheduler.
// Table-driven vectors plus hand-written reset and timeout sequences.
module tb_mux16_rr_scheduler;

   localparam int TB_MAX_HOLD = 4;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic        done;
   logic [15:0] gnt;
   logic [3:0]  sel;
   logic        valid;
   logic        preempt;

   int checks;
   int failures;

   typedef struct {
      logic [15:0] req;
      logic        done;
      logic [15:0] gnt;
      logic [3:0]  sel;
      logic        valid;
   } vec_t;

   vec_t vecs[$];

   mux16_rr_scheduler #(
      .MAX_HOLD  (TB_MAX_HOLD),
      .PTR_RESET (0)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .sel     (sel),
      .valid   (valid),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic add(input logic [15:0] r, input logic d,
                      input logic [15:0] g, input logic [3:0] s,
                      input logic v);
      vec_t e;
      e.req   = r;
      e.done  = d;
      e.gnt   = g;
      e.sel   = s;
      e.valid = v;
      vecs.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = 16'h0;
      done  = 1'b0;
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic chk_out(input string name, input logic [15:0] g,
                          input logic [3:0] s, input logic v,
                          input logic p);
      chk({name, ".gnt"}, gnt, g);
      chk({name, ".sel"}, 16'(sel), 16'(s));
      chk({name, ".valid"}, 16'(valid), 16'(v));
      chk({name, ".preempt"}, 16'(preempt), 16'(p));
   endtask

   initial begin
      logic [3:0] nk;
      checks   = 0;
      failures = 0;
      req      = 16'h0;
      done     = 1'b0;
      rst_n    = 1'b0;

      // Full rotation with done every second cycle.
      add(16'hFFFF, 1'b0, 16'h0001, 4'd0, 1'b1);
      for (int k = 0; k < 16; k++) begin
         nk = 4'(k + 1);
         add(16'hFFFF, 1'b0, 16'd1 << k, 4'(k), 1'b1);
         add(16'hFFFF, 1'b1, 16'd1 << nk, nk, 1'b1);
      end
      // Owner 0 drops, ptr -> 1.
      add(16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0);
      // Single requester grant and done release.
      add(16'h0001, 1'b0, 16'h0001, 4'd0, 1'b1);
      add(16'h0001, 1'b1, 16'h0000, 4'd0, 1'b0);
      add(16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0);
      // Owner 13, then wrap from ptr 14 to 0, then 3.
      add(16'h2000, 1'b0, 16'h2000, 4'd13, 1'b1);
      add(16'h0009, 1'b0, 16'h0001, 4'd0, 1'b1);
      add(16'h0009, 1'b1, 16'h0008, 4'd3, 1'b1);
      add(16'h0008, 1'b1, 16'h0000, 4'd3, 1'b0);
      // Owner 5 drops its request while 8 waits.
      add(16'h0020, 1'b0, 16'h0020, 4'd5, 1'b1);
      add(16'h0120, 1'b0, 16'h0020, 4'd5, 1'b1);
      add(16'h0100, 1'b0, 16'h0100, 4'd8, 1'b1);
      add(16'h0000, 1'b0, 16'h0000, 4'd8, 1'b0);
      // Owner not re-granted on its own release edge.
      add(16'h0100, 1'b0, 16'h0100, 4'd8, 1'b1);
      add(16'h0100, 1'b1, 16'h0000, 4'd8, 1'b0);
      add(16'h0000, 1'b0, 16'h0000, 4'd8, 1'b0);

      #1;
      chk_out("reset_async", 16'h0, 4'd0, 1'b0, 1'b0);
      do_reset();
      chk_out("reset_rel", 16'h0, 4'd0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         req  = vecs[i].req;
         done = vecs[i].done;
         step();
         chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel,
                 vecs[i].valid, 1'b0);
      end
      done = 1'b0;

      // Reset mid-grant with owner 7 (ptr currently 9).
      req = 16'h0080;
      step();
      chk_out("pre_rst", 16'h0080, 4'd7, 1'b1, 1'b0);
      #2;
      req   = 16'h0180;
      rst_n = 1'b0;
      #1;
      chk_out("mid_rst", 16'h0, 4'd0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk_out("post_rst", 16'h0080, 4'd7, 1'b1, 1'b0);
      // Release 7 so ptr becomes 8, then reset: search must restart at 0.
      req  = 16'h0000;
      done = 1'b1;
      step();
      chk_out("ptr8_idle", 16'h0, 4'd7, 1'b0, 1'b0);
      done = 1'b0;
      do_reset();
      req = 16'h0180;
      step();
      chk_out("ptr_reset", 16'h0080, 4'd7, 1'b1, 1'b0);

      // Owner 2 never signals done while 4 competes.
      do_reset();
      req = 16'h0004;
      step();
      chk_out("to_e0", 16'h0004, 4'd2, 1'b1, 1'b0);
      req = 16'h0014;
      for (int c = 1; c < 4; c++) begin
         step();
         chk_out($sformatf("to_e%0d", c), 16'h0004, 4'd2, 1'b1, 1'b0);
      end
      step();
`ifdef ARB_TIMEOUT_EN
      chk_out("to_e4", 16'h0010, 4'd4, 1'b1, 1'b1);
      step();
      chk_out("to_e5", 16'h0010, 4'd4, 1'b1, 1'b0);
`else
      chk_out("to_e4", 16'h0004, 4'd2, 1'b1, 1'b0);
      step();
      chk_out("to_e5", 16'h0004, 4'd2, 1'b1, 1'b0);
`endif

      // No competitor: grant kept indefinitely, never preempted.
      do_reset();
      req = 16'h0004;
      for (int c = 0; c < 12; c++) begin
         step();
         chk_out($sformatf("solo%0d", c), 16'h0004, 4'd2, 1'b1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
